// File: rtl/layer2_argmax.sv
// Output layer of the SDRAM MLP: ReLU(hidden) x W2 dot products, saturated scores
// written back over Avalon-MM, and the argmax reported as class_id.
module layer2_argmax #(
  parameter int N_HID      = 200,
  parameter int N_OUT      = 10,
  parameter int L1_BASE    = 400_000,
  parameter int W2_BASE    = 320_000,
  parameter int OUT_BASE   = 500_000,
  parameter int FRAC_SHIFT = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        waitrequest,
  input  logic        readdatavalid,
  input  logic [15:0] readdata,
  output logic        chipselect,
  output logic [1:0]  byteenable,
  output logic        read_n,
  output logic        write_n,
  output logic [31:0] address,
  output logic [15:0] writedata,
  input  logic        ready,
  output logic        done,
  output logic [3:0]  class_id,
  output logic [31:0] toHexLed
);

  typedef enum logic [3:0] {
    IDLE = 4'd0, RD_H, WT_H, RD_W, WT_W, MAC, SAT, WRITE, NEXT, DONE
  } state_t;

  localparam logic [15:0] HID_LAST = 16'(N_HID - 1);
  localparam logic [3:0]  OUT_LAST = 4'(N_OUT - 1);
  localparam logic [31:0] L1_A     = 32'(L1_BASE);
  localparam logic [31:0] W2_A     = 32'(W2_BASE);
  localparam logic [31:0] OUT_A    = 32'(OUT_BASE);
  localparam logic [31:0] N_HID_A  = 32'(N_HID);

  state_t             state, state_nxt;
  logic [3:0]         state_bits;
  logic [15:0]        hid_i;
  logic [3:0]         out_j;
  logic [3:0]         best_idx;
  logic signed [15:0] h, w, best_val, score;
  logic signed [31:0] acc, prod, h_ext, w_ext;

  function automatic logic signed [15:0] sat16(input logic signed [31:0] x);
    logic signed [31:0] sh;
    sh = x >>> FRAC_SHIFT;
    if (sh > 32'sd32767)       return 16'sh7fff;
    else if (sh < -32'sd32768) return 16'sh8000;
    else                       return sh[15:0];
  endfunction

  assign h_ext      = {{16{h[15]}}, h};
  assign w_ext      = {{16{w[15]}}, w};
  assign prod       = h_ext * w_ext;
  assign score      = sat16(acc);
  assign state_bits = state;
  assign chipselect = 1'b1;
  assign byteenable = 2'b11;
  assign toHexLed   = {20'h0, class_id, 4'h0, state_bits};

  always_comb begin
    state_nxt = state;
    read_n    = 1'b1;
    write_n   = 1'b1;
    done      = 1'b0;
    address   = '0;
    case (state)
      IDLE: if (ready) state_nxt = RD_H;
      RD_H: begin
        read_n  = 1'b0;
        address = L1_A + {15'd0, hid_i, 1'b0};
        if (!waitrequest) state_nxt = WT_H;
      end
      WT_H: if (readdatavalid) state_nxt = RD_W;
      RD_W: begin
        read_n  = 1'b0;
        address = W2_A + ((({28'd0, out_j} * N_HID_A) + {16'd0, hid_i}) << 1);
        if (!waitrequest) state_nxt = WT_W;
      end
      WT_W: if (readdatavalid) state_nxt = MAC;
      MAC:  state_nxt = (hid_i == HID_LAST) ? SAT : RD_H;
      SAT:  state_nxt = WRITE;
      WRITE: begin
        write_n = 1'b0;
        address = OUT_A + {27'd0, out_j, 1'b0};
        if (!waitrequest) state_nxt = NEXT;
      end
      NEXT: state_nxt = (out_j == OUT_LAST) ? DONE : RD_H;
      DONE: begin
        done = 1'b1;
        if (!ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath updates are keyed on the current state; the request outputs above are pure decode.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      acc       <= '0;
      hid_i     <= '0;
      out_j     <= '0;
      h         <= '0;
      w         <= '0;
      best_val  <= 16'sh8000;
      best_idx  <= '0;
      writedata <= '0;
      class_id  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          acc      <= '0;
          hid_i    <= '0;
          out_j    <= '0;
          best_val <= 16'sh8000;
          best_idx <= '0;
        end
        WT_H: if (readdatavalid) h <= readdata[15] ? 16'sd0 : $signed(readdata);
        WT_W: if (readdatavalid) w <= $signed(readdata);
        MAC: begin
          acc <= acc + prod;
          if (hid_i != HID_LAST) hid_i <= hid_i + 16'd1;
        end
        SAT: begin
          writedata <= score;
          // Strict compare: on ties the earlier (lower) index wins.
          if (score > best_val) begin
            best_val <= score;
            best_idx <= out_j;
          end
        end
        NEXT: begin
          acc   <= '0;
          hid_i <= '0;
          if (out_j == OUT_LAST) class_id <= best_idx;
          else                   out_j    <= out_j + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
